sd_crc_engine: RTL

Parametrised, streaming CRC generator for the SD host path: one engine computes CRC7 for command frames or CRC16-CCITT for data blocks, taking 1–32 message bits per beat. It replaces the fixed 40-bit, lookup-table CRC7 calculator, needs no table memory, accepts frames of any length, and absorbs one beat per clock. It sits between the SD command/data packers and the line serialisers.

---
 rtl/sd_crc_pkg.sv | 14 +
 rtl/sd_crc_step.sv | 28 ++
 rtl/sd_crc_engine.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sd_crc_pkg.sv
// sd_crc_pkg: shared constants for the SD CRC engine.
// Holds the SD CRC7/CRC16 generator polynomials and the FSM state codes.
package sd_crc_pkg;

    localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;
    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;

    typedef logic [1:0] sd_crc_state_t;

    localparam sd_crc_state_t ST_IDLE = 2'd0;
    localparam sd_crc_state_t ST_BUSY = 2'd1;
    localparam sd_crc_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/sd_crc_step.sv
// sd_crc_step: combinational single-beat CRC update (DATA_W serial LFSR steps).
// Ports: i_crc (current register), i_data (beat, MSB first), o_crc (updated).
module sd_crc_step #(
    parameter int                 CRC_W  = 7,
    parameter logic [CRC_W-1:0]   POLY   = 7'h09,
    parameter int                 DATA_W = 8
) (
    input  logic [CRC_W-1:0]  i_crc,
    input  logic [DATA_W-1:0] i_data,
    output logic [CRC_W-1:0]  o_crc
);

    logic [CRC_W-1:0] w_acc;
    logic             w_fb;

    // Unrolled bit-serial LFSR: highest data bit enters first.
    always_comb begin
        w_acc = i_crc;
        w_fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_fb  = w_acc[CRC_W-1] ^ i_data[i];
            w_acc = {w_acc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

    assign o_crc = w_acc;

endmodule

// File: rtl/sd_crc_engine.sv
// sd_crc_engine: streaming CRC7/CRC16 generator, one DATA_W-bit beat per clock.
// Ports: sys_clk, sys_rst (sync, active-high), abort; in_data/in_valid/in_last/
// in_ready beat input; crc_out/out_valid/out_ready result handoff; beat_cnt.
// Optional macro SD_CRC_CHECK_EN adds exp_crc (in) and crc_ok (out) compare.
module sd_crc_engine
    import sd_crc_pkg::*;
#(
    parameter int               CRC_W  = 7,
    parameter logic [CRC_W-1:0] POLY   = SD_CRC7_POLY,
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter int               DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef SD_CRC_CHECK_EN
    input  logic [CRC_W-1:0]  exp_crc,
    output logic              crc_ok,
`endif
    output logic [15:0]       beat_cnt
);

    sd_crc_state_t    r_state;
    sd_crc_state_t    w_next;
    logic [CRC_W-1:0] r_crc;
    logic [15:0]      r_beat_cnt;
    logic             r_out_valid;
    logic             w_ready;
    logic             w_accept;
    logic             w_first;
    logic [CRC_W-1:0] w_base;
    logic [CRC_W-1:0] w_step;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides any transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_BUSY: begin
                if (w_accept) begin
                    w_next = in_last ? ST_DONE : ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (abort) begin
            w_next = ST_IDLE;
        end
    end

    // Output decode
    always_comb begin
        w_ready  = (r_state != ST_DONE);
        w_accept = in_valid && w_ready;
        w_first  = (r_state == ST_IDLE);
    end

    // A new frame always starts from INIT regardless of the register.
    assign w_base = w_first ? INIT : r_crc;

    sd_crc_step #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_step (
        .i_crc  (w_base),
        .i_data (in_data),
        .o_crc  (w_step)
    );

    // Datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst || abort) begin
            r_crc       <= INIT;
            r_beat_cnt  <= 16'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_next == ST_DONE);
            if (w_accept) begin
                r_crc <= w_step;
                if (w_first) begin
                    r_beat_cnt <= 16'd1;
                end else if (r_beat_cnt != 16'hFFFF) begin
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                end
            end else if (r_state == ST_DONE && out_ready) begin
                r_crc <= INIT;
            end
        end
    end

`ifdef SD_CRC_CHECK_EN
    logic r_crc_ok;

    // Compare against exp_crc as presented with the last beat.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || abort) begin
            r_crc_ok <= 1'b0;
        end else if (w_accept && in_last) begin
            r_crc_ok <= (w_step == exp_crc);
        end else if (r_state == ST_DONE && out_ready) begin
            r_crc_ok <= 1'b0;
        end
    end

    assign crc_ok = r_crc_ok;
`endif

    assign in_ready  = w_ready;
    assign crc_out   = r_crc;
    assign out_valid = r_out_valid;
    assign beat_cnt  = r_beat_cnt;

endmodule
